// File: rtl/serial_tx_8bit.sv
// Start/8N/stop serial transmitter for one 8-bit word. Bit timing advances only on
// Ce-qualified cycles; accepting a new word does not wait for Ce.
module serial_tx_8bit #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Ce,
    input  logic       send,
    input  logic [7:0] Din,
    output logic       Sout,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [7:0] CNT_MAX = 8'(CLKS_PER_BIT - 1);

    state_t     state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bitidx_q, bitidx_d;
    logic       sout_q, sout_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shreg_q  <= 8'h00;
            cnt_q    <= 8'h00;
            bitidx_q <= 3'd0;
            sout_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            bitidx_q <= bitidx_d;
            sout_q   <= sout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        bitidx_d = bitidx_q;
        sout_d   = sout_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        if (state_q == IDLE) begin
            sout_d = 1'b1;
            if (send) begin
                shreg_d  = Din;
                cnt_d    = 8'h00;
                bitidx_d = 3'd0;
                busy_d   = 1'b1;
                sout_d   = 1'b0;
                state_d  = START;
            end
        end else if (Ce) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 8'd1;
            end else begin
                // Bit boundary: decide what goes on the line for the next bit.
                cnt_d = 8'h00;
                case (state_q)
                    START: begin
                        state_d = DATA;
                        sout_d  = shreg_q[0];
                    end
                    DATA: begin
                        if (bitidx_q != 3'd7) begin
                            shreg_d  = {1'b0, shreg_q[7:1]};
                            sout_d   = shreg_q[1];
                            bitidx_d = bitidx_q + 3'd1;
                        end else begin
                            sout_d  = 1'b1;
                            state_d = STOP;
                        end
                    end
                    STOP: begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    assign Sout = sout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_tx_8bit.sv
// Directed bench for serial_tx_8bit: one instance at 4 clocks/bit with Ce tied high,
// one at 2 clocks/bit driven with a toggling Ce.
module tb_serial_tx_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce4, ce2;
    logic       send4, send2;
    logic [7:0] din;
    logic       sout4, busy4, done4;
    logic       sout2, busy2, done2;

    int vectors = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    serial_tx_8bit #(.CLKS_PER_BIT(4)) u4 (
        .clk(clk), .rst(rst), .Ce(ce4), .send(send4), .Din(din),
        .Sout(sout4), .busy(busy4), .done(done4)
    );

    serial_tx_8bit #(.CLKS_PER_BIT(2)) u2 (
        .clk(clk), .rst(rst), .Ce(ce2), .send(send2), .Din(din),
        .Sout(sout2), .busy(busy2), .done(done2)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends d on u4 and checks every cycle through the done edge (edge 40).
    // With inject set, a send of 8'hFF is pulsed in the middle of the data bits.
    task automatic frame4(input logic [7:0] d, input bit inject, input string tag);
        logic [9:0] fr;
        fr    = {1'b1, d, 1'b0};
        send4 = 1'b1;
        din   = d;
        tick();
        send4 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            chk({tag, " sout"}, sout4, fr[k / 4]);
            chk({tag, " busy"}, busy4, 1'b1);
            chk({tag, " done"}, done4, 1'b0);
            if (inject && k == 20) begin
                send4 = 1'b1;
                din   = 8'hFF;
            end else if (inject && k == 21) begin
                send4 = 1'b0;
            end
            tick();
        end
        chk({tag, " end sout"}, sout4, 1'b1);
        chk({tag, " end busy"}, busy4, 1'b0);
        chk({tag, " end done"}, done4, 1'b1);
    endtask

    initial begin
        logic [9:0] fr;
        rst   = 1'b1;
        ce4   = 1'b1;
        ce2   = 1'b1;
        send4 = 1'b0;
        send2 = 1'b0;
        din   = 8'h00;

        // Reset: two cycles, then idle line everywhere.
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rst sout4", sout4, 1'b1);
            chk("rst busy4", busy4, 1'b0);
            chk("rst done4", done4, 1'b0);
            chk("rst sout2", sout2, 1'b1);
            chk("rst busy2", busy2, 1'b0);
            chk("rst done2", done2, 1'b0);
            tick();
        end

        // Single frame A5.
        frame4(8'hA5, 1'b0, "A5");
        tick();
        chk("A5 done drop", done4, 1'b0);
        chk("A5 idle sout", sout4, 1'b1);

        // Ce gating on the N=2 instance: Ce high on even edges after accept.
        fr    = {1'b1, 8'h0F, 1'b0};
        send2 = 1'b1;
        din   = 8'h0F;
        ce2   = 1'b0;
        tick();
        send2 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            chk("0F sout", sout2, fr[k / 4]);
            chk("0F busy", busy2, 1'b1);
            chk("0F done", done2, 1'b0);
            ce2 = ((k + 1) % 2 == 0);
            tick();
        end
        chk("0F end busy", busy2, 1'b0);
        chk("0F end done", done2, 1'b1);
        chk("0F end sout", sout2, 1'b1);
        ce2 = 1'b1;
        tick();
        chk("0F done drop", done2, 1'b0);

        // Ignored send mid-DATA; Din also left changed afterwards.
        frame4(8'h3C, 1'b1, "3C");
        tick();
        chk("3C single done", done4, 1'b0);
        chk("3C idle busy", busy4, 1'b0);

        // Back-to-back: second send is raised in the done cycle of the first.
        frame4(8'h55, 1'b0, "55");
        frame4(8'h81, 1'b0, "81");
        tick();
        chk("81 done drop", done4, 1'b0);

        // Reset during data bit 3 of C3 (data bit 3 spans edges 16..19).
        fr    = {1'b1, 8'hC3, 1'b0};
        send4 = 1'b1;
        din   = 8'hC3;
        tick();
        send4 = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            chk("C3 sout", sout4, fr[k / 4]);
            chk("C3 busy", busy4, 1'b1);
            if (k < 16) tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort sout", sout4, 1'b1);
        chk("abort busy", busy4, 1'b0);
        chk("abort done", done4, 1'b0);
        for (int i = 0; i < 45; i++) begin
            chk("abort no done", done4, 1'b0);
            chk("abort idle sout", sout4, 1'b1);
            tick();
        end
        frame4(8'h12, 1'b0, "12");
        tick();
        chk("12 done drop", done4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/serial_tx_8bit.md
# serial_tx_8bit

Parallel-to-serial transmitter that drains one 8-bit word, such as the output of an 8-bit Ce-gated register, onto a single-wire serial line. Frame format: start bit (0), 8 data bits LSB first, stop bit (1). Bit timing advances only on cycles with `Ce` high, so the block shares the clock-enable style of the register bank. It is the read/unload side of the register datapath; a matching deserializer is the receive side.

## Interface
- `CLKS_PER_BIT`, default 4: number of Ce-qualified clock cycles per serial bit; legal range 1..255.
- `clk` input, 1 bit: sole clock, rising-edge.
- `rst` input, 1 bit: synchronous, active-high reset. Sampled on the rising edge of `clk`.
- `Ce` input, 1 bit: bit-timing enable. The bit counter advances only when `Ce`=1.
- `send` input, 1 bit: request to transmit `Din`. Accepted only when `busy`=0.
- `Din` input, 8 bits: word to transmit, captured on the accept edge.
- `Sout` output, 1 bit: serial line. Idles at 1.
- `busy` output, 1 bit: high while a frame is in progress.
- `done` output, 1 bit: one-cycle pulse when a frame completes.

## Operation
- The FSM has four states: IDLE, START, DATA and STOP. It also holds `shreg[7:0]`, `cnt[7:0]` (bit timer) and `bitidx[2:0]`.
- Reset values: state=IDLE, `Sout`=1, `busy`=0, `done`=0, `shreg`=0, `cnt`=0, `bitidx`=0.
- `rst` has priority over all other inputs. Reset mid-frame aborts the frame, and `Sout` returns to 1 at the next edge. No `done` pulse is generated for an aborted frame.
- **IDLE:** `Sout`=1. On an edge with `send`=1:
  - `shreg`<=`Din`, `cnt`<=0, `bitidx`<=0, `busy`<=1, `Sout`<=0, state<=START.
  - Accept does not depend on `Ce`.
- **Timing rule in START, DATA and STOP:** on an edge with `Ce`=1:
  - If `cnt`==`CLKS_PER_BIT`-1, the bit ends: `cnt`<=0.
  - Otherwise `cnt`<=`cnt`+1.
  - With `Ce`=0, all state, counters and `Sout` hold.
- **START bit end:** state<=DATA, `Sout`<=`shreg[0]`.
- **DATA bit end:**
  - If `bitidx`<7: `shreg` shifts right, `Sout`<=`shreg[1]`, `bitidx`++.
  - If `bitidx`==7: `Sout`<=1, state<=STOP.
- **STOP bit end:** state<=IDLE, `busy`<=0, `done`<=1.
- `done` is forced to 0 on every edge where it is not set by the STOP bit end.
- `send` while `busy`=1 is ignored: no queueing, and `Din` is not sampled.
- A `send` on the cycle `done`=1 is accepted, because the block is already in IDLE. This allows back-to-back frames with no idle gap.
- Changes on `Din` after the accept edge do not affect the frame in progress.

## Timing
- Edges are numbered relative to the accept edge, which is edge 0. The figures below assume `Ce` held at 1 and `CLKS_PER_BIT`=N.
- `Sout`=0 after edges 0..N-1.
- Data bit i is on `Sout` after edges N(i+1)..N(i+2)-1, for i=0..7.
- Stop bit is on `Sout` after edges 9N..10N-1.
- At edge 10N: `busy`=0 and `done`=1. `done`=0 again after edge 10N+1.
- `busy` is high for exactly 10N cycles. Each cycle of `Ce`=0 stretches the frame by one cycle.
- With N=1, every edge with `Ce`=1 advances one bit, and the frame lasts 10 Ce-cycles.
- Latency from `send` to the start bit on `Sout` is 1 edge.

## Test plan
- **Reset:** `rst`=1 for 2 cycles, then `send`=0 -> `Sout`=1, `busy`=0, `done`=0, held indefinitely.
- **Single frame:** N=4, `Ce`=1, `Din`=8'hA5, `send` for 1 cycle.
  - `Sout` sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1.
  - `busy` is high for 40 cycles.
  - `done` pulses exactly once at edge 40.
- **Ce gating:** N=2, `Din`=8'h0F, `Ce` toggling 1,0,1,0.
  - Each bit lasts 4 clk cycles and the frame lasts 40 cycles.
  - Bit pattern is 0,1,1,1,1,0,0,0,0,1.
- **Ignored send:** during a frame of 8'h3C, pulse `send` with `Din`=8'hFF mid-DATA.
  - Transmitted bits are still those of 8'h3C.
  - Only one `done` pulse occurs.
- **Back-to-back:** assert `send` with `Din`=8'h81 on the `done` cycle of a prior 8'h55 frame.
  - The start bit follows the stop bit with no idle cycle.
  - Both frames decode correctly.
- **Reset mid-frame:** assert `rst` during data bit 3 of 8'hC3.
  - `Sout`=1 and `busy`=0 after the edge, with no `done` pulse.
  - A new `send` of 8'h12 then transmits correctly.
